// File: rtl/ethsim_pkg.sv
// Shared types and sizing helpers for the Ethernet traffic generator.
// Frame geometry is derived here so every port engine agrees on it.
package ethsim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SEND,
    GAP,
    TDONE
  } tx_state_t;

  function automatic int cnt_w(input int max_pkt);
    return $clog2(max_pkt + 1);
  endfunction

  function automatic int beats(input int len);
    return (len + 7) / 8;
  endfunction

  function automatic logic [7:0] last_keep(input int len);
    int r;
    r = len % 8;
    return (r == 0) ? 8'hFF : 8'((1 << r) - 1);
  endfunction

endpackage

// File: rtl/ethsim_port_engine.sv
// One PHY channel: patterned frame transmitter plus returning-frame checker.
// TX and RX share only the start strobe; RX runs even while TX is idle.
module ethsim_port_engine
  import ethsim_pkg::*;
#(
  parameter int PORT        = 0,
  parameter int NUM_TXPKT   = 10,
  parameter int MAX_RECVPKT = 10,
  parameter int PKT_LEN     = 64,
  parameter int N_PREAMBLE  = 8,
  parameter int N_IFG       = 12,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_run,
  input  logic             tx_tready,
  output logic             tx_tvalid,
  output logic [63:0]      tx_tdata,
  output logic [7:0]       tx_tkeep,
  output logic             tx_tlast,
  output logic             tx_tuser,
  output logic             tx_done,
  output logic             rx_tready,
  input  logic             rx_tvalid,
  input  logic [63:0]      rx_tdata,
  input  logic [7:0]       rx_tkeep,
  input  logic             rx_tlast,
  input  logic             rx_tuser,
  output logic [CNT_W-1:0] rx_pkt_cnt,
  output logic             rx_err
);

  localparam logic [7:0]  LAST_B  = 8'(beats(PKT_LEN) - 1);
  localparam logic [7:0]  LAST_K  = last_keep(PKT_LEN);
  localparam logic [15:0] PRE_END = 16'(N_PREAMBLE - 1);
  localparam logic [15:0] IFG_END = 16'(N_IFG - 1);
  localparam logic [15:0] SEQ_END = 16'(NUM_TXPKT - 1);
  localparam logic [15:0] SEQ_NUM = 16'(NUM_TXPKT);
  localparam logic [15:0] FR_LEN  = 16'(PKT_LEN);
  localparam logic [7:0]  PORT_B  = 8'(PORT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RECVPKT);

  tx_state_t   state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] seq_q, seq_d;
  logic [7:0]  beat_q, beat_d;
  logic        last_beat;

  logic [15:0]      bytes_q, bytes_d, tot;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             rdy_q;
  logic             mism, keep_ok;

  function automatic logic [7:0] pat(
    input logic [15:0] k,
    input logic [7:0]  seq
  );
    if (k == 16'd0) return PORT_B;
    if (k == 16'd1) return seq;
    return k[7:0];
  endfunction

  assign last_beat = beat_q == LAST_B;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    seq_d   = seq_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE, TDONE: begin
        if (start_run) begin
          seq_d   = '0;
          beat_d  = '0;
          wait_d  = '0;
          state_d = (N_PREAMBLE == 0) ? SEND : PRE;
        end
      end
      PRE: begin
        if (wait_q == PRE_END) begin
          wait_d  = '0;
          state_d = SEND;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      SEND: begin
        if (tx_tready) begin
          if (last_beat) begin
            beat_d = '0;
            seq_d  = seq_q + 16'd1;
            wait_d = '0;
            if (N_IFG != 0) state_d = GAP;
            else if (seq_q == SEQ_END) state_d = TDONE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      GAP: begin
        if (wait_q == IFG_END) begin
          wait_d  = '0;
          state_d = (seq_q == SEQ_NUM) ? TDONE : SEND;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes past the end of the frame are driven as zero.
  always_comb begin
    tx_tvalid = state_q == SEND;
    tx_tlast  = tx_tvalid && last_beat;
    tx_tkeep  = '0;
    tx_tdata  = '0;
    if (tx_tvalid) tx_tkeep = last_beat ? LAST_K : 8'hFF;
    for (int l = 0; l < 8; l++) begin
      if (tx_tkeep[l]) begin
        tx_tdata[8*l +: 8] =
          pat({5'd0, beat_q, 3'(l)}, seq_q[7:0]);
      end
    end
  end

  assign tx_tuser = 1'b0;
  assign tx_done  = state_q == TDONE;

  // Byte 1 is checked against itself, so the sequence number is free.
  always_comb begin
    mism = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (rx_tkeep[l] &&
          rx_tdata[8*l +: 8] !=
          pat(bytes_q + 16'(l), rx_tdata[8*l +: 8]))
        mism = 1'b1;
    end
    keep_ok = (rx_tkeep != 8'd0) &&
              (((rx_tkeep + 8'd1) & rx_tkeep) == 8'd0);
    tot = bytes_q + 16'($countones(rx_tkeep));
  end

  always_comb begin
    bytes_d = bytes_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (start_run) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
    if (rx_tvalid) begin
      if (!keep_ok) err_d = 1'b1;
      if (rx_tlast) begin
        bytes_d = '0;
        bad_d   = 1'b0;
        if (rx_tuser || bad_q || mism || tot != FR_LEN)
          err_d = 1'b1;
        else if (cnt_d == CNT_MAX)
          err_d = 1'b1;
        else
          cnt_d = cnt_d + 1'b1;
      end else begin
        bytes_d = tot;
        bad_d   = bad_q || mism;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      seq_q   <= '0;
      beat_q  <= '0;
      bytes_q <= '0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      seq_q   <= seq_d;
      beat_q  <= beat_d;
      bytes_q <= bytes_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  assign rx_tready  = rdy_q;
  assign rx_pkt_cnt = cnt_q;
  assign rx_err     = err_q;

endmodule

// File: rtl/ethsim_traffic_gen.sv
// NPORTS-channel Ethernet traffic source/sink with a global done/err summary.
// Only start gating, completion tracking and bus slicing live here.
module ethsim_traffic_gen
  import ethsim_pkg::*;
#(
  parameter int NPORTS      = 4,
  parameter int NUM_TXPKT   = 10,
  parameter int MAX_RECVPKT = 10,
  parameter int PKT_LEN     = 64,
  parameter int N_PREAMBLE  = 8,
  parameter int N_IFG       = 12,
  parameter int CNT_W       = cnt_w(MAX_RECVPKT)
) (
  input  logic                    clk156,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [NPORTS-1:0]       tx_tready,
  output logic [NPORTS-1:0]       tx_tvalid,
  output logic [NPORTS*64-1:0]    tx_tdata,
  output logic [NPORTS*8-1:0]     tx_tkeep,
  output logic [NPORTS-1:0]       tx_tlast,
  output logic [NPORTS-1:0]       tx_tuser,
  output logic [NPORTS-1:0]       rx_tready,
  input  logic [NPORTS-1:0]       rx_tvalid,
  input  logic [NPORTS*64-1:0]    rx_tdata,
  input  logic [NPORTS*8-1:0]     rx_tkeep,
  input  logic [NPORTS-1:0]       rx_tlast,
  input  logic [NPORTS-1:0]       rx_tuser,
  output logic [NPORTS*CNT_W-1:0] rx_pkt_cnt,
  output logic [NPORTS-1:0]       rx_err
);

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_run;
  logic              all_done;
  logic [NPORTS-1:0] tx_fin;
  logic [NPORTS-1:0] port_done;

  assign start_run = start && !busy_q;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    ethsim_port_engine #(
      .PORT       (p),
      .NUM_TXPKT  (NUM_TXPKT),
      .MAX_RECVPKT(MAX_RECVPKT),
      .PKT_LEN    (PKT_LEN),
      .N_PREAMBLE (N_PREAMBLE),
      .N_IFG      (N_IFG),
      .CNT_W      (CNT_W)
    ) u_eng (
      .clk       (clk156),
      .rst       (rst),
      .start_run (start_run),
      .tx_tready (tx_tready[p]),
      .tx_tvalid (tx_tvalid[p]),
      .tx_tdata  (tx_tdata[64*p +: 64]),
      .tx_tkeep  (tx_tkeep[8*p +: 8]),
      .tx_tlast  (tx_tlast[p]),
      .tx_tuser  (tx_tuser[p]),
      .tx_done   (tx_fin[p]),
      .rx_tready (rx_tready[p]),
      .rx_tvalid (rx_tvalid[p]),
      .rx_tdata  (rx_tdata[64*p +: 64]),
      .rx_tkeep  (rx_tkeep[8*p +: 8]),
      .rx_tlast  (rx_tlast[p]),
      .rx_tuser  (rx_tuser[p]),
      .rx_pkt_cnt(rx_pkt_cnt[CNT_W*p +: CNT_W]),
      .rx_err    (rx_err[p])
    );

    assign port_done[p] = tx_fin[p] &&
      (rx_pkt_cnt[CNT_W*p +: CNT_W] == CNT_W'(MAX_RECVPKT));
  end

  assign all_done = &port_done;

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    if (start_run) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q && all_done) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk156) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = |rx_err;

endmodule

// File: tb/tb_ethsim_traffic_gen.sv
// Scoreboard bench: expected TX beats are queued at start and popped on
// each handshake; RX behaviour is exercised by loopback and direct drive.
module tb_ethsim_traffic_gen;

  localparam int NP   = 4;
  localparam int NT   = 10;
  localparam int NB   = 8;
  localparam int LEN  = 64;
  localparam int NIFG = 12;
  localparam int CW   = 4;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  always #3 clk = ~clk;

  logic rst, start, busy, done, err;
  logic [NP-1:0]    tx_tready, tx_tvalid, tx_tlast, tx_tuser;
  logic [NP*64-1:0] tx_tdata;
  logic [NP*8-1:0]  tx_tkeep;
  logic [NP-1:0]    rx_tready, rx_tvalid, rx_tlast, rx_tuser;
  logic [NP*64-1:0] rx_tdata;
  logic [NP*8-1:0]  rx_tkeep;
  logic [NP*CW-1:0] rx_pkt_cnt;
  logic [NP-1:0]    rx_err;

  bit lb, cor_arm, cor_en, tog2;
  logic [NP-1:0]    drv_valid, drv_last, drv_user;
  logic [NP*64-1:0] drv_data;
  logic [NP*8-1:0]  drv_keep;

  logic        s_start, s_busy, s_done, s_err;
  logic        s_tv, s_tl, s_tu, s_rrdy, s_rerr;
  logic [63:0] s_td;
  logic [7:0]  s_tk;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  beat_t exp_q[NP][$];
  int    gap_cnt[NP];
  int    fr_cnt[NP];
  int    bt_cnt[NP];
  bit    in_gap[NP];
  bit    stall_q[NP];
  beat_t hold_q[NP];

  always_comb begin
    rx_tvalid = lb ? (tx_tvalid & tx_tready) : drv_valid;
    rx_tdata  = lb ? tx_tdata : drv_data;
    rx_tkeep  = lb ? tx_tkeep : drv_keep;
    rx_tlast  = lb ? tx_tlast : drv_last;
    rx_tuser  = lb ? '0 : drv_user;
    if (lb && cor_en) rx_tdata[64+40 +: 8] = 8'h00;
  end

  ethsim_traffic_gen dut (
    .clk156(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .err(err),
    .tx_tready(tx_tready), .tx_tvalid(tx_tvalid),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep),
    .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
    .rx_tready(rx_tready), .rx_tvalid(rx_tvalid),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .rx_pkt_cnt(rx_pkt_cnt), .rx_err(rx_err)
  );

  ethsim_traffic_gen #(
    .NPORTS(1), .PKT_LEN(61), .N_PREAMBLE(0), .N_IFG(0)
  ) dut61 (
    .clk156(clk), .rst(rst), .start(s_start),
    .busy(s_busy), .done(s_done), .err(s_err),
    .tx_tready(1'b1), .tx_tvalid(s_tv),
    .tx_tdata(s_td), .tx_tkeep(s_tk),
    .tx_tlast(s_tl), .tx_tuser(s_tu),
    .rx_tready(s_rrdy), .rx_tvalid(s_tv),
    .rx_tdata(s_td), .rx_tkeep(s_tk),
    .rx_tlast(s_tl), .rx_tuser(1'b0),
    .rx_pkt_cnt(s_cnt), .rx_err(s_rerr)
  );

  function automatic beat_t mk_beat(input int p, input int f,
                                    input int b, input int len);
    beat_t r;
    int    k;
    r.d = '0;
    r.k = 8'hFF;
    r.l = (b == (len + 7) / 8 - 1);
    if (r.l && (len % 8) != 0) r.k = 8'((1 << (len % 8)) - 1);
    for (int l = 0; l < 8; l++) begin
      k = b * 8 + l;
      if (k < len)
        r.d[8*l +: 8] = (k == 0) ? 8'(p) : (k == 1) ? 8'(f) : 8'(k);
    end
    return r;
  endfunction

  task automatic clear_sb();
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      fr_cnt[p]  = 0;
      bt_cnt[p]  = 0;
      gap_cnt[p] = 0;
      in_gap[p]  = 0;
      stall_q[p] = 0;
    end
  endtask

  task automatic push_run();
    clear_sb();
    for (int p = 0; p < NP; p++)
      for (int f = 0; f < NT; f++)
        for (int b = 0; b < NB; b++)
          exp_q[p].push_back(mk_beat(p, f, b, LEN));
  endtask

  task automatic step();
    beat_t got, e;
    @(negedge clk);
    if (tog2) tx_tready[2] = ~tx_tready[2];
    cor_en = cor_arm && fr_cnt[1] == 3 && bt_cnt[1] == 0;
    for (int p = 0; p < NP; p++) begin
      got.d = tx_tdata[64*p +: 64];
      got.k = tx_tkeep[8*p +: 8];
      got.l = tx_tlast[p];
      if (stall_q[p]) begin
        checks++;
        if (tx_tvalid[p] !== 1'b1 || got !== hold_q[p]) begin
          errors++;
          $display("FAIL stall_hold p%0d: got v=%b %h, need v=1 %h",
                   p, tx_tvalid[p], got, hold_q[p]);
        end
      end
      if (tx_tvalid[p] === 1'b1 && in_gap[p]) begin
        checks++;
        if (gap_cnt[p] != NIFG) begin
          errors++;
          $display("FAIL ifg p%0d: got %0d idle, need %0d",
                   p, gap_cnt[p], NIFG);
        end
        in_gap[p] = 0;
      end else if (in_gap[p]) begin
        gap_cnt[p]++;
      end
      if (tx_tvalid[p] === 1'b1 && tx_tready[p] === 1'b1) begin
        checks++;
        if (exp_q[p].size() == 0) begin
          errors++;
          $display("FAIL tx_extra p%0d: got %h, need no beat", p, got);
        end else begin
          e = exp_q[p].pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL tx_beat p%0d f%0d b%0d: got %h, need %h",
                     p, fr_cnt[p], bt_cnt[p], got, e);
          end
        end
        if (got.l) begin
          fr_cnt[p]++;
          bt_cnt[p]  = 0;
          in_gap[p]  = 1;
          gap_cnt[p] = 0;
        end else begin
          bt_cnt[p]++;
        end
      end
      stall_q[p] = tx_tvalid[p] === 1'b1 && tx_tready[p] === 1'b0;
      hold_q[p]  = got;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_sb();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser} !== '0) begin
      errors++;
      $display("FAIL reset_tx: got v=%b l=%b u=%b, need all 0",
               tx_tvalid, tx_tlast, tx_tuser);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got b/d/e=%b%b%b, need 000",
               busy, done, err);
    end
    checks++;
    if (rx_pkt_cnt !== '0 || rx_err !== '0) begin
      errors++;
      $display("FAIL reset_rx: got cnt=%h err=%b, need 0",
               rx_pkt_cnt, rx_err);
    end
    checks++;
    if (rx_tready !== '0) begin
      errors++;
      $display("FAIL reset_rdy: got %b, need 0000", rx_tready);
    end
    rst = 1'b0;
    clear_sb();
    step();
    checks++;
    if (rx_tready !== '1 || s_rrdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_rst: got %b/%b, need 1111/1",
               rx_tready, s_rrdy);
    end
  endtask

  task automatic check_run_end(input string tag);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: got d/e/b=%b%b%b, need 100",
               tag, done, err, busy);
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (rx_pkt_cnt[CW*p +: CW] !== 4'(NT) || exp_q[p].size() != 0)
      begin
        errors++;
        $display("FAIL %s_cnt p%0d: got cnt=%0d left=%0d, need %0d/0",
                 tag, p, rx_pkt_cnt[CW*p +: CW], exp_q[p].size(), NT);
      end
    end
  endtask

  task automatic test_loopback(input bit toggle2, input bit restart);
    lb = 1;
    tx_tready = '1;
    tog2 = toggle2;
    push_run();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || rx_err !== '0 ||
        rx_pkt_cnt !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_clear: got b=%b e=%b re=%b cnt=%h d=%b",
               busy, err, rx_err, rx_pkt_cnt, done);
    end
    for (int c = 0; c < 1500 && done !== 1'b1; c++) begin
      if (restart && c == 40) start = 1'b1;
      step();
      start = 1'b0;
    end
    tog2 = 0;
    tx_tready = '1;
    check_run_end(toggle2 ? "stall" : restart ? "rerun" : "loop");
  endtask

  task automatic test_corrupt();
    do_reset();
    lb = 1;
    tx_tready = '1;
    cor_arm = 1;
    push_run();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 400; c++) step();
    cor_arm = 0;
    checks++;
    if (rx_err !== 4'b0010 || err !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_flags: got re=%b e=%b d=%b, need 0010 1 0",
               rx_err, err, done);
    end
    checks++;
    if (rx_pkt_cnt !== {4'd10, 4'd10, 4'd9, 4'd10}) begin
      errors++;
      $display("FAIL corrupt_cnt: got %h, need aa9a", rx_pkt_cnt);
    end
  endtask

  task automatic send_frame(input int p, input int f,
                            input bit user, input int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b = mk_beat(p, f, i, LEN);
      drv_valid[p]         = 1'b1;
      drv_data[64*p +: 64] = b.d;
      drv_keep[8*p +: 8]   = b.k;
      drv_last[p]          = (i == nb - 1);
      drv_user[p]          = user && (i == nb - 1);
      step();
    end
    drv_valid[p] = 1'b0;
    drv_last[p]  = 1'b0;
    drv_user[p]  = 1'b0;
    step();
  endtask

  task automatic test_rx_errors();
    do_reset();
    lb = 0;
    send_frame(0, 0, 1, NB);
    checks++;
    if (rx_err !== 4'b0001 || rx_pkt_cnt[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL rx_tuser: got re=%b cnt0=%0d, need 0001/0",
               rx_err, rx_pkt_cnt[3:0]);
    end
    for (int f = 0; f < NT; f++) send_frame(3, f, 0, NB);
    checks++;
    if (rx_err[3] !== 1'b0 || rx_pkt_cnt[15:12] !== 4'd10) begin
      errors++;
      $display("FAIL rx_fill p3: got re=%b cnt=%0d, need 0/10",
               rx_err[3], rx_pkt_cnt[15:12]);
    end
    send_frame(3, 10, 0, NB);
    checks++;
    if (rx_err[3] !== 1'b1 || rx_pkt_cnt[15:12] !== 4'd10) begin
      errors++;
      $display("FAIL rx_ovf p3: got re=%b cnt=%0d, need 1/10",
               rx_err[3], rx_pkt_cnt[15:12]);
    end
    drv_valid[2]       = 1'b1;
    drv_keep[8*2 +: 8] = 8'h00;
    step();
    drv_valid[2] = 1'b0;
    step();
    checks++;
    if (rx_err[2] !== 1'b1) begin
      errors++;
      $display("FAIL rx_keep0 p2: got %b, need 1", rx_err[2]);
    end
    send_frame(1, 0, 0, NB - 1);
    checks++;
    if (rx_err !== 4'b1111 || err !== 1'b1 || done !== 1'b0 ||
        rx_pkt_cnt[7:4] !== 4'd0) begin
      errors++;
      $display("FAIL rx_short: got re=%b e=%b d=%b cnt1=%0d",
               rx_err, err, done, rx_pkt_cnt[7:4]);
    end
  endtask

  task automatic test_rst_mid();
    int c;
    do_reset();
    lb = 1;
    tx_tready = '1;
    push_run();
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (bt_cnt[0] != 5 && c < 200) begin
      step();
      c++;
    end
    checks++;
    if (c >= 200) begin
      errors++;
      $display("FAIL rst_mid_wait: got timeout, need beat 4");
    end
    rst = 1'b1;
    step();
    checks++;
    if ({tx_tvalid, tx_tdata, tx_tkeep, tx_tlast} !== '0 ||
        {busy, done, err} !== 3'b000 || rx_tready !== '0 ||
        rx_pkt_cnt !== '0 || rx_err !== '0) begin
      errors++;
      $display("FAIL rst_mid_clear: got v=%b bde=%b%b%b rdy=%b cnt=%h",
               tx_tvalid, busy, done, err, rx_tready, rx_pkt_cnt);
    end
    rst = 1'b0;
    clear_sb();
    step();
    test_loopback(0, 0);
  endtask

  task automatic test_len61();
    int beats_seen, idle;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    checks++;
    if (s_tv !== 1'b1) begin
      errors++;
      $display("FAIL pre0_valid: got %b, need 1", s_tv);
    end
    beats_seen = 0;
    idle = 0;
    for (int c = 0; c < 300 && beats_seen < 80; c++) begin
      if (s_tv === 1'b1) begin
        if (s_tl === 1'b1) begin
          checks++;
          if (s_tk !== 8'h1F || beats_seen % 8 != 7 ||
              s_td !== 64'h0000_003C_3B3A_3938) begin
            errors++;
            $display("FAIL len61_last: got k=%h b=%0d d=%h, need 1f 7",
                     s_tk, beats_seen % 8, s_td);
          end
        end
        beats_seen++;
      end else begin
        idle++;
      end
      step();
    end
    checks++;
    if (beats_seen != 80 || idle != 0) begin
      errors++;
      $display("FAIL len61_b2b: got %0d beats %0d idle, need 80/0",
               beats_seen, idle);
    end
    for (int c = 0; c < 10 && s_done !== 1'b1; c++) step();
    checks++;
    if (s_done !== 1'b1 || s_err !== 1'b0 || s_cnt !== 4'd10 ||
        s_busy !== 1'b0 || s_rerr !== 1'b0 || s_tu !== 1'b0) begin
      errors++;
      $display("FAIL len61_end: got d=%b e=%b cnt=%0d b=%b",
               s_done, s_err, s_cnt, s_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    s_start = 1'b0;
    lb = 0;
    cor_arm = 0;
    cor_en = 0;
    tog2 = 0;
    tx_tready = '1;
    drv_valid = '0;
    drv_last = '0;
    drv_user = '0;
    drv_data = '0;
    drv_keep = '0;
    clear_sb();
    test_reset();
    test_loopback(0, 0);
    test_loopback(1, 0);
    test_corrupt();
    test_rx_errors();
    test_loopback(0, 1);
    test_rst_mid();
    test_len61();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ethsim_traffic_gen.md
Name: ethsim_traffic_gen

Overview:
Parametrised, self-checking Ethernet traffic source and sink for the PHY-side AXI-Stream ports of the DUT. It generalises the fixed four-PHY simulation harness to NPORTS channels. Each channel transmits a programmed number of patterned frames with configurable preamble-equivalent lead-in and IFG, and checks and counts frames returned on its RX port. A global done/error summary lets the simulation terminate itself.

Parameters:
NPORTS, 4, number of PHY channels
NUM_TXPKT, 10, frames transmitted per port per run
MAX_RECVPKT, 10, frames expected per RX port before that port counts as complete
PKT_LEN, 64, frame length in bytes, legal range 16..1518
N_PREAMBLE, 8, idle cycles between start and the first beat on every port
N_IFG, 12, idle cycles (tvalid low) after each accepted tlast beat

Ports:
clk156  in  1  156.25 MHz clock; only clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a run on all ports
busy  out  1  run in progress
done  out  1  sticky; every port finished TX and received MAX_RECVPKT frames
err  out  1  sticky OR of all per-port errors
tx_tready  in  NPORTS  per-port TX ready
tx_tvalid  out  NPORTS  per-port TX valid
tx_tdata  out  NPORTS*64  port p occupies [64p+63:64p]
tx_tkeep  out  NPORTS*8  byte enables
tx_tlast  out  NPORTS  end of frame
tx_tuser  out  NPORTS  always 0
rx_tready  out  NPORTS  always 1 outside reset
rx_tvalid  in  NPORTS  per-port RX valid
rx_tdata  in  NPORTS*64
rx_tkeep  in  NPORTS*8
rx_tlast  in  NPORTS
rx_tuser  in  NPORTS  error marker on the tlast beat
rx_pkt_cnt  out  NPORTS*CNT_W  per-port good-frame count, saturating at MAX_RECVPKT
rx_err  out  NPORTS  per-port sticky error

Behaviour:
- Reset values: all tx_* = 0; rx_tready = 0 during the rst cycle and 1 from the next cycle; busy = done = err = 0; counts and rx_err = 0.
- Frame pattern: byte 0 = port index[7:0]; byte 1 = sequence number[7:0] (0..NUM_TXPKT-1); byte k≥2 = k[7:0].
- Beat layout: byte k sits in beat k/8, lane k%8, at tdata[8*(k%8)+:8].
- Beats per frame = ceil(PKT_LEN/8). Non-last beats use tkeep = 0xFF. The last beat uses tkeep = (1<<(PKT_LEN%8))-1, or 0xFF when PKT_LEN%8 = 0.
- TX FSM per port:
  - IDLE -> PRE on start.
  - PRE: wait N_PREAMBLE cycles, then SEND.
  - SEND: assert tvalid; hold tdata, tkeep and tlast stable until tvalid&tready. Advance the beat counter only on handshake. The tlast handshake goes to GAP.
  - GAP: N_IFG cycles with tvalid low, then SEND if frames remain, else TDONE.
  - N_IFG = 0 allows back-to-back frames. N_PREAMBLE = 0 asserts tvalid the cycle after start.
- RX checker per port:
  - Accept every beat with rx_tvalid high.
  - Compare enabled bytes k≥2 against the pattern and byte 0 against the port index.
  - Track the frame byte count as a running sum of tkeep popcount.
  - At tlast: if tuser=1, pattern mismatch, or byte count ≠ PKT_LEN, set rx_err; else increment rx_pkt_cnt (saturating).
  - A good frame arriving when the count already equals MAX_RECVPKT sets rx_err (overflow).
  - tkeep non-contiguous or zero on a valid beat sets rx_err.
- busy rises the cycle after start and falls when done sets.
- done = all ports in TDONE AND every rx_pkt_cnt == MAX_RECVPKT.
- A start while busy is ignored.
- A start while idle or done clears done, err, counts and rx_err, then begins a new run.
- rst mid-frame: all outputs reach reset values the next cycle. A partial RX frame is discarded without flagging an error.
- RX is independent of TX state: frames arriving before start are checked and counted.

Decomposition:
- Package ethsim_pkg:
  - CNT_W = $clog2(MAX_RECVPKT+1), passed as a parameter function.
  - Beat-count and last-tkeep helper functions.
  - tx_state_t enum {IDLE, PRE, SEND, GAP, TDONE}.
- Sub-module ethsim_port_engine: one TX FSM plus one RX checker, instantiated NPORTS times in a generate loop.
- The top holds only start/done/err aggregation and bus slicing.

Test Plan:
- Loopback tx→rx on all ports, tready=1, defaults → each port sends 10 frames of 8 beats with last tkeep 0xFF and exactly 12 idle cycles between frames; done=1, err=0, every rx_pkt_cnt=10.
- PKT_LEN=61 loopback → last beat (beat 7) tkeep=0x1F; counts reach 10 with no errors.
- Port 2 tready toggling 1-0 each cycle → tdata stable while stalled; the frame still takes 8 handshakes; done still sets.
- Corrupt byte 5 of frame 3 on port 1 RX (value 0x00) → rx_err[1]=1, err=1, rx_pkt_cnt[1]=9, done stays 0.
- rx_tuser=1 on the tlast beat of port 0 → rx_err[0]=1; an 11th good frame on port 3 → rx_err[3]=1 with count held at 10.
- Assert rst during beat 4 of a frame, then pulse start → all outputs cleared the cycle after rst; the new run completes with done=1, err=0.
